// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program-counter generator. Selects the next PC
//                from trap / exception-return / branch / return / jump /
//                stall / sequential sources in fixed priority, keeps a small
//                circular return-address stack and an exception-PC register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h40),
    parameter int unsigned     INC       = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stall_i,
    input  logic                         br_take_i,
    input  logic [XLEN-1:0]              br_tgt_i,
    input  logic                         jmp_i,
    input  logic [XLEN-1:0]              jmp_tgt_i,
    input  logic                         call_i,
    input  logic                         ret_i,
    input  logic [XLEN-1:0]              ret_tgt_i,
    input  logic                         trap_i,
    input  logic                         eret_i,
    output logic [XLEN-1:0]              pc_o,
    output logic [XLEN-1:0]              pc_next_o,
    output logic [XLEN-1:0]              epc_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt_o,
    output logic                         ras_miss_o
);

    localparam int unsigned          c_ptr_w    = $clog2(RAS_DEPTH);
    localparam int unsigned          c_cnt_w    = c_ptr_w + 1;
    localparam logic [XLEN-1:0]      c_inc      = XLEN'(INC);
    localparam logic [c_ptr_w-1:0]   c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_full = c_cnt_w'(RAS_DEPTH);

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_epc;
    logic [XLEN-1:0]    r_ras_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ras_ptr;
    logic [c_cnt_w-1:0] r_ras_cnt;
    logic               r_ras_miss;

    logic [XLEN-1:0]    w_pc_next;
    logic [XLEN-1:0]    w_pc_inc;
    logic [XLEN-1:0]    w_ras_top;
    logic               w_push;
    logic               w_pop;
    logic               w_miss;
    logic               w_epc_we;

    // Sequential successor (wraps modulo 2^XLEN) and the most recent RAS entry
    assign w_pc_inc  = r_pc + c_inc;
    assign w_ras_top = r_ras_mem[r_ras_ptr - c_ptr_one];

    // Prioritised next-PC selection; only the winning event raises a side effect
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_miss    = 1'b0;
        w_epc_we  = 1'b0;
        if (start_i) begin
            if (trap_i) begin
                w_pc_next = TRAP_VEC;
                w_epc_we  = 1'b1;
            end else if (eret_i) begin
                w_pc_next = r_epc;
            end else if (br_take_i) begin
                w_pc_next = br_tgt_i;
            end else if (ret_i) begin
                if (r_ras_cnt != '0) begin
                    w_pc_next = w_ras_top;
                    w_pop     = 1'b1;
                end else begin
                    // Empty stack: fall back to the architectural target
                    w_pc_next = ret_tgt_i;
                    w_miss    = 1'b1;
                end
            end else if (jmp_i) begin
                w_pc_next = jmp_tgt_i;
                w_push    = call_i;
            end else if (stall_i) begin
                w_pc_next = r_pc;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    // PC, EPC, RAS pointer/count and miss pulse; everything frozen while start_i is low
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_ras_ptr  <= '0;
            r_ras_cnt  <= '0;
            r_ras_miss <= 1'b0;
        end else begin
            r_ras_miss <= w_miss;
            if (start_i) begin
                r_pc <= w_pc_next;
                if (w_epc_we) begin
                    r_epc <= r_pc;
                end
                if (w_push) begin
                    // A push when full overwrites the oldest entry; count saturates
                    r_ras_ptr <= r_ras_ptr + c_ptr_one;
                    if (r_ras_cnt != c_cnt_full) begin
                        r_ras_cnt <= r_ras_cnt + c_cnt_one;
                    end
                end else if (w_pop) begin
                    r_ras_ptr <= r_ras_ptr - c_ptr_one;
                    r_ras_cnt <= r_ras_cnt - c_cnt_one;
                end
            end
        end
    end

    // RAS storage has no reset; contents are only read when the count says valid
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_ras_mem[r_ras_ptr] <= w_pc_inc;
        end
    end

    assign pc_o       = r_pc;
    assign pc_next_o  = w_pc_next;
    assign epc_o      = r_epc;
    assign ras_cnt_o  = r_ras_cnt;
    assign ras_miss_o = r_ras_miss;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed scenarios plus a
//                randomized run against a queue-based reference model. A
//                second 16-bit instance exercises address wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance stimulus / observation
    logic        rst, start, stall, br_take, jmp, call, ret, trap, eret;
    logic [31:0] br_tgt, jmp_tgt, ret_tgt;
    logic [31:0] pc, pc_next, epc;
    logic [2:0]  ras_cnt;
    logic        ras_miss;

    // 16-bit instance stimulus / observation
    logic        rst2, start2, jmp2, call2, ret2;
    logic [15:0] jmp_tgt2;
    logic [15:0] pc2, pc_next2, epc2;
    logic [2:0]  ras_cnt2;
    logic        ras_miss2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic [31:0] m_ras[$];
    logic        m_miss;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h40), .INC(4), .RAS_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .br_take_i(br_take), .br_tgt_i(br_tgt), .jmp_i(jmp), .jmp_tgt_i(jmp_tgt),
        .call_i(call), .ret_i(ret), .ret_tgt_i(ret_tgt), .trap_i(trap), .eret_i(eret),
        .pc_o(pc), .pc_next_o(pc_next), .epc_o(epc), .ras_cnt_o(ras_cnt), .ras_miss_o(ras_miss)
    );

    pc_gen #(.XLEN(16), .RESET_VEC(16'hFFF8), .TRAP_VEC(16'h0040), .INC(4), .RAS_DEPTH(4)) dut16 (
        .clk_i(clk), .rst_i(rst2), .start_i(start2), .stall_i(1'b0),
        .br_take_i(1'b0), .br_tgt_i(16'h0), .jmp_i(jmp2), .jmp_tgt_i(jmp_tgt2),
        .call_i(call2), .ret_i(ret2), .ret_tgt_i(16'h0), .trap_i(1'b0), .eret_i(1'b0),
        .pc_o(pc2), .pc_next_o(pc_next2), .epc_o(epc2), .ras_cnt_o(ras_cnt2), .ras_miss_o(ras_miss2)
    );

    // Expected next PC from the priority rules applied to the model state
    function automatic logic [31:0] exp_next();
        if (!start)  return m_pc;
        if (trap)    return 32'h40;
        if (eret)    return m_epc;
        if (br_take) return br_tgt;
        if (ret)     return (m_ras.size() > 0) ? m_ras[$] : ret_tgt;
        if (jmp)     return jmp_tgt;
        if (stall)   return m_pc;
        return m_pc + 32'd4;
    endfunction

    task automatic clear_inputs();
        start = 1'b0; stall = 1'b0; br_take = 1'b0; jmp = 1'b0; call = 1'b0;
        ret = 1'b0; trap = 1'b0; eret = 1'b0;
        br_tgt = '0; jmp_tgt = '0; ret_tgt = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_miss = 1'b0;
    endtask

    // Advance one clock on the 32-bit instance and move the model along with it
    task automatic step();
        logic [31:0] nxt;
        logic        w_trap, w_ret, w_call;
        nxt    = exp_next();
        w_trap = start && trap;
        w_ret  = start && !trap && !eret && !br_take && ret;
        w_call = start && !trap && !eret && !br_take && !ret && jmp && call;
        @(posedge clk); #1;
        m_miss = w_ret && (m_ras.size() == 0);
        if (w_trap) m_epc = m_pc;
        if (w_ret && m_ras.size() > 0) void'(m_ras.pop_back());
        if (w_call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = nxt;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #12;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
        n_checks++; if (ras_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", ras_cnt); end
        n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss got %b want 0", ras_miss); end
        @(negedge clk); rst = 1'b0; model_reset();
        start = 1'b1;
        step(); step();
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL pre_async_pc got %h want %h", pc, 32'h8); end
        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc got %h want %h", pc, 32'h0); end
        #2 rst = 1'b0; model_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(4 * i)); end
        end
        start = 1'b0;
        #1;
        n_checks++; if (pc_next !== 32'hC) begin n_fail++; $display("FAIL hold_pc_next got %h want %h", pc_next, 32'hC); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL hold_pc[%0d] got %h want %h", i, pc, 32'hC); end
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        start = 1'b1; jmp = 1'b1; jmp_tgt = 32'h20;
        step();
        jmp = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, 32'h20); end
        end
        br_take = 1'b1; br_tgt = 32'h80;
        #1;
        n_checks++; if (pc_next !== 32'h80) begin n_fail++; $display("FAIL stall_br_next got %h want %h", pc_next, 32'h80); end
        step();
        n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL stall_br_pc got %h want %h", pc, 32'h80); end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        start = 1'b1; jmp = 1'b1; jmp_tgt = 32'h30;
        step();
        trap = 1'b1; eret = 1'b1; br_take = 1'b1; br_tgt = 32'h900;
        call = 1'b1; jmp_tgt = 32'hA00; ret = 1'b1; ret_tgt = 32'hB00;
        step();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL prio_pc got %h want %h", pc, 32'h40); end
        n_checks++; if (epc !== 32'h30) begin n_fail++; $display("FAIL prio_epc got %h want %h", epc, 32'h30); end
        n_checks++; if (ras_cnt !== 3'd0) begin n_fail++; $display("FAIL prio_cnt got %0d want 0", ras_cnt); end
        n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL prio_miss got %b want 0", ras_miss); end
        clear_inputs(); start = 1'b1; eret = 1'b1;
        step();
        n_checks++; if (pc !== 32'h30) begin n_fail++; $display("FAIL eret_pc got %h want %h", pc, 32'h30); end
        n_checks++; if (epc !== 32'h30) begin n_fail++; $display("FAIL eret_epc got %h want %h", epc, 32'h30); end
        clear_inputs();
    endtask

    task automatic test_ras_call_ret();
        do_reset();
        start = 1'b1; jmp = 1'b1; jmp_tgt = 32'h10;
        step();
        call = 1'b1; jmp_tgt = 32'h100;
        step();
        n_checks++; if (pc !== 32'h100 || ras_cnt !== 3'd1) begin n_fail++; $display("FAIL call1 got pc=%h cnt=%0d want pc=100 cnt=1", pc, ras_cnt); end
        jmp = 1'b0; call = 1'b0;
        step();
        jmp = 1'b1; call = 1'b1; jmp_tgt = 32'h200;
        step();
        n_checks++; if (pc !== 32'h200 || ras_cnt !== 3'd2) begin n_fail++; $display("FAIL call2 got pc=%h cnt=%0d want pc=200 cnt=2", pc, ras_cnt); end
        jmp = 1'b0; call = 1'b0; ret = 1'b1; ret_tgt = 32'hDEAD;
        step();
        n_checks++; if (pc !== 32'h108 || ras_cnt !== 3'd1) begin n_fail++; $display("FAIL ret1 got pc=%h cnt=%0d want pc=108 cnt=1", pc, ras_cnt); end
        step();
        n_checks++; if (pc !== 32'h14 || ras_cnt !== 3'd0) begin n_fail++; $display("FAIL ret2 got pc=%h cnt=%0d want pc=14 cnt=0", pc, ras_cnt); end
        n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL ret2_miss got %b want 0", ras_miss); end
        ret_tgt = 32'h500;
        step();
        n_checks++; if (pc !== 32'h500 || ras_miss !== 1'b1) begin n_fail++; $display("FAIL ret3 got pc=%h miss=%b want pc=500 miss=1", pc, ras_miss); end
        ret = 1'b0;
        step();
        n_checks++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL miss_pulse got %b want 0", ras_miss); end
        clear_inputs();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] pushed [5];
        logic [31:0] cur;
        do_reset();
        start = 1'b1; cur = 32'h0;
        for (int i = 0; i < 5; i++) begin
            pushed[i] = cur + 32'd4;
            jmp = 1'b1; call = 1'b1;
            jmp_tgt = 32'h1000 * (i + 1) + ($urandom & 32'hFFC);
            cur = jmp_tgt;
            step();
        end
        n_checks++; if (ras_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt got %0d want 4", ras_cnt); end
        jmp = 1'b0; call = 1'b0; ret = 1'b1; ret_tgt = 32'hBEEF0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (pc !== pushed[4 - i] || ras_miss !== 1'b0) begin n_fail++; $display("FAIL ovf_ret[%0d] got pc=%h miss=%b want pc=%h miss=0", i, pc, ras_miss, pushed[4 - i]); end
        end
        step();
        n_checks++; if (pc !== 32'hBEEF0 || ras_miss !== 1'b1 || ras_cnt !== 3'd0) begin n_fail++; $display("FAIL ovf_ret5 got pc=%h miss=%b cnt=%0d want pc=beef0 miss=1 cnt=0", pc, ras_miss, ras_cnt); end
        clear_inputs();
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            start   = ($urandom_range(0, 7) != 0);
            trap    = ($urandom_range(0, 15) == 0);
            eret    = ($urandom_range(0, 15) == 0);
            br_take = ($urandom_range(0, 7) == 0);
            ret     = ($urandom_range(0, 5) == 0);
            jmp     = ($urandom_range(0, 4) == 0);
            call    = ($urandom_range(0, 1) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            br_tgt  = $urandom & 32'hFFFF_FFFC;
            jmp_tgt = $urandom & 32'hFFFF_FFFC;
            ret_tgt = $urandom & 32'hFFFF_FFFC;
            #1;
            n_checks++;
            if (pc_next !== exp_next()) begin
                n_fail++;
                if (errs++ < 10) $display("FAIL rand_next[%0d] got %h want %h", i, pc_next, exp_next());
            end
            step();
            n_checks++;
            if (pc !== m_pc || epc !== m_epc || ras_cnt !== 3'(m_ras.size()) || ras_miss !== m_miss) begin
                n_fail++;
                if (errs++ < 10) $display("FAIL rand_state[%0d] got pc=%h epc=%h cnt=%0d miss=%b want pc=%h epc=%h cnt=%0d miss=%b",
                                          i, pc, epc, ras_cnt, ras_miss, m_pc, m_epc, m_ras.size(), m_miss);
            end
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'hFFFC; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0004;
        start2 = 1'b0; jmp2 = 1'b0; call2 = 1'b0; ret2 = 1'b0; jmp_tgt2 = '0;
        @(negedge clk); rst2 = 1'b1;
        #1;
        n_checks++; if (pc2 !== 16'hFFF8) begin n_fail++; $display("FAIL wrap_reset got %h want %h", pc2, 16'hFFF8); end
        @(negedge clk); rst2 = 1'b0; start2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (pc2 !== exp_seq[i]) begin n_fail++; $display("FAIL wrap_seq[%0d] got %h want %h", i, pc2, exp_seq[i]); end
        end
        start2 = 1'b0;
        @(negedge clk); rst2 = 1'b1;
        @(negedge clk); rst2 = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        jmp2 = 1'b1; call2 = 1'b1; jmp_tgt2 = 16'h0100;
        @(posedge clk); #1;
        n_checks++; if (pc2 !== 16'h0100 || ras_cnt2 !== 3'd1) begin n_fail++; $display("FAIL wrap_call got pc=%h cnt=%0d want pc=0100 cnt=1", pc2, ras_cnt2); end
        jmp2 = 1'b0; call2 = 1'b0; ret2 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (pc2 !== 16'h0000 || ras_miss2 !== 1'b0) begin n_fail++; $display("FAIL wrap_ret got pc=%h miss=%b want pc=0000 miss=0", pc2, ras_miss2); end
        ret2 = 1'b0; start2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        start2 = 1'b0; jmp2 = 1'b0; call2 = 1'b0; ret2 = 1'b0; jmp_tgt2 = '0;
        clear_inputs();
        model_reset();
        test_reset();
        test_stall_redirect();
        test_priority();
        test_ras_call_ret();
        test_ras_overflow();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
